// File: rtl/rst_req_ctrl.sv
// rst_req_ctrl: merges masked reset requests into one pulse with a minimum high time and a post-release holdoff,
// and records which sources fired plus a saturating count of assertions.
module rst_req_ctrl #(
    parameter int NUM_SRC   = 4,
    parameter int MIN_PULSE = 16,
    parameter int HOLDOFF   = 8,
    parameter int CNT_W     = 8
) (
    input  logic               ref_clk_i,
    input  logic               glob_arst_i,
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [NUM_SRC-1:0] req_mask_i,
    input  logic               cause_clr_i,
    output logic               arst_req_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] cause_o,
    output logic [CNT_W-1:0]   rst_cnt_o
);
    localparam int TMAX = MIN_PULSE > HOLDOFF ? MIN_PULSE : HOLDOFF;
    localparam int TW   = TMAX > 2 ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LD = TW'(MIN_PULSE - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD, COOLDOWN} state_t;
    // With no holdoff the release goes straight back to IDLE for one low cycle.
    localparam state_t REL = HOLDOFF == 0 ? IDLE : COOLDOWN;
    state_t            state;
    logic [TW-1:0]     timer;
    logic              pending;
    logic [NUM_SRC-1:0] eff;
    logic              active;
    logic [CNT_W-1:0]  cnt_inc;
    assign eff     = req_i & ~req_mask_i;
    assign active  = |eff;
    assign cnt_inc = &rst_cnt_o ? rst_cnt_o : rst_cnt_o + 1'b1;
    always_ff @(posedge ref_clk_i or posedge glob_arst_i) begin
        if (glob_arst_i) begin
            state      <= IDLE;
            timer      <= '0;
            pending    <= 1'b0;
            arst_req_o <= 1'b0;
            busy_o     <= 1'b0;
            cause_o    <= '0;
            rst_cnt_o  <= '0;
        end else begin
            cause_o <= (state == IDLE && cause_clr_i) ? eff : cause_o | eff;
            case (state)
                IDLE: if (active) begin
                    state      <= ASSERT;
                    arst_req_o <= 1'b1;
                    busy_o     <= 1'b1;
                    timer      <= PULSE_LD;
                    rst_cnt_o  <= cnt_inc;
                end
                ASSERT, HOLD: begin
                    if (state == ASSERT && timer != '0) timer <= timer - 1'b1;
                    else if (active) state <= HOLD;
                    else begin
                        state      <= REL;
                        arst_req_o <= 1'b0;
                        busy_o     <= HOLDOFF != 0;
                        timer      <= HOLD_LD;
                    end
                end
                COOLDOWN: begin
                    if (timer != '0) begin
                        timer   <= timer - 1'b1;
                        pending <= pending | active;
                    end else if (pending || active) begin
                        state      <= ASSERT;
                        arst_req_o <= 1'b1;
                        timer      <= PULSE_LD;
                        rst_cnt_o  <= cnt_inc;
                        pending    <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb_rst_req_ctrl: scoreboard bench; each scenario queues the expected {arst_req_o, busy_o} per cycle and
// drive() pops and compares them as the cycles run.
module tb_rst_req_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0, mask = '0, req2 = '0;
    logic       clr = 1'b0;
    logic       arst, busy, arst2, busy2;
    logic [3:0] cause, cause2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rst_req_ctrl dut (
        .ref_clk_i(clk), .glob_arst_i(rst), .req_i(req), .req_mask_i(mask), .cause_clr_i(clr),
        .arst_req_o(arst), .busy_o(busy), .cause_o(cause), .rst_cnt_o(cnt)
    );

    rst_req_ctrl #(.MIN_PULSE(1), .HOLDOFF(0), .CNT_W(2)) dut2 (
        .ref_clk_i(clk), .glob_arst_i(rst), .req_i(req2), .req_mask_i(4'b0000), .cause_clr_i(1'b0),
        .arst_req_o(arst2), .busy_o(busy2), .cause_o(cause2), .rst_cnt_o(cnt2)
    );

    task automatic push(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({a, b});
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic c, input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            req = r; mask = m; clr = c;
            @(negedge clk);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: DUT cycle at %0t has no queued expectation", $time);
            end else begin
                e = exp_q.pop_front();
                if (arst !== e[1]) begin
                    fails++;
                    $display("FAIL arst at %0t: got %b want %b", $time, arst, e[1]);
                end
                tests++;
                if (busy !== e[0]) begin
                    fails++;
                    $display("FAIL busy at %0t: got %b want %b", $time, busy, e[0]);
                end
            end
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] c_exp, input logic [7:0] n_exp);
        tests++;
        if (cause !== c_exp) begin
            fails++;
            $display("FAIL %s cause: got %b want %b", name, cause, c_exp);
        end
        tests++;
        if (cnt !== n_exp) begin
            fails++;
            $display("FAIL %s cnt: got %0d want %0d", name, cnt, n_exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        req = '0; mask = '0; clr = 1'b0; req2 = '0;
        rst = 1'b1;
        #1;
        tests++;
        if ({arst, busy, cause, cnt, arst2, busy2, cnt2} !== '0) begin
            fails++;
            $display("FAIL reset: got arst=%b busy=%b cause=%b cnt=%0d arst2=%b cnt2=%0d want all 0",
                     arst, busy, cause, cnt, arst2, cnt2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        test_reset();
        push(0, 0, 50);
        drive('0, '0, 0, 50);
        check_state("idle", 4'b0000, 0);
    endtask

    task automatic test_pulse();
        test_reset();
        push(1, 1, 16); push(0, 1, 8); push(0, 0, 2);
        drive(4'b0010, '0, 0, 1);
        drive('0, '0, 0, 25);
        check_state("pulse", 4'b0010, 1);
    endtask

    task automatic test_hold();
        test_reset();
        push(1, 1, 40); push(0, 1, 8); push(0, 0, 1);
        drive(4'b0001, '0, 0, 40);
        drive('0, '0, 0, 9);
        check_state("hold", 4'b0001, 1);
    endtask

    task automatic test_retrigger();
        test_reset();
        push(1, 1, 16); push(0, 1, 8); push(1, 1, 16); push(0, 1, 8); push(0, 0, 1);
        drive(4'b0010, '0, 0, 1);
        drive('0, '0, 0, 17);
        drive(4'b0100, '0, 0, 1);
        drive('0, '0, 0, 30);
        check_state("retrigger", 4'b0110, 2);
    endtask

    // Runs straight after test_retrigger, so cause starts at 0110.
    task automatic test_clear();
        push(1, 1, 20); push(0, 1, 8); push(0, 0, 1);
        drive(4'b0001, '0, 1, 1);
        check_state("clear", 4'b0001, 3);
        drive(4'b0101, '0, 1, 1);
        drive(4'b0001, '0, 1, 18);
        drive(4'b0001, 4'b0001, 0, 9);
        check_state("clear_ignored", 4'b0101, 3);
    endtask

    task automatic test_mask();
        test_reset();
        push(0, 0, 6);
        drive(4'b1000, 4'b1000, 0, 3);
        drive('0, 4'b1000, 0, 3);
        check_state("mask", 4'b0000, 0);
    endtask

    task automatic test_async_reset();
        test_reset();
        push(1, 1, 5);
        drive(4'b0010, '0, 0, 1);
        drive('0, '0, 0, 4);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({arst, busy, cause, cnt} !== '0) begin
            fails++;
            $display("FAIL async_reset: got arst=%b busy=%b cause=%b cnt=%0d want all 0", arst, busy, cause, cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        push(0, 0, 3);
        drive('0, '0, 0, 3);
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        test_reset();
        for (int k = 1; k <= 5; k++) begin
            want = k > 3 ? 2'd3 : 2'(k);
            req2 = 4'b0100;
            @(negedge clk);
            tests++;
            if (arst2 !== 1'b1 || cnt2 !== want) begin
                fails++;
                $display("FAIL sat_trig%0d: got arst2=%b cnt2=%0d want 1 %0d", k, arst2, cnt2, want);
            end
            req2 = '0;
            @(negedge clk);
            tests++;
            if (arst2 !== 1'b0 || busy2 !== 1'b0) begin
                fails++;
                $display("FAIL sat_rel%0d: got arst2=%b busy2=%b want 0 0", k, arst2, busy2);
            end
        end
        tests++;
        if (cause2 !== 4'b0100) begin
            fails++;
            $display("FAIL sat_cause: got %b want 0100", cause2);
        end
    endtask

    initial begin
        test_idle();
        test_pulse();
        test_hold();
        test_retrigger();
        test_clear();
        test_mask();
        test_async_reset();
        test_saturate();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rst_req_ctrl.md
Name: rst_req_ctrl

Overview:
Upstream reset-request controller for the CRG async-reset output stage. It collects several synchronous reset-request sources, such as software and watchdog requests, and applies a per-source mask. It drives a single clean `arst_req_o` that feeds the downstream stage's `arst_req_i`, with a guaranteed minimum pulse width and a post-release holdoff. It also records which sources caused the reset and counts reset events.

Parameters:
- NUM_SRC, 4: number of request sources; range 1 to 16.
- MIN_PULSE, 16: minimum `arst_req_o` high time in ref_clk_i cycles; must be 1 or more.
- HOLDOFF, 8: cycles `arst_req_o` is held low after release before a new assertion is allowed; 0 is legal.
- CNT_W, 8: width of the reset event counter.

Ports:
- ref_clk_i, input, 1: reference clock; all logic is on the rising edge.
- glob_arst_i, input, 1: asynchronous, active-high global reset.
- req_i, input, NUM_SRC: level reset requests, already synchronous to ref_clk_i.
- req_mask_i, input, NUM_SRC: 1 = source ignored.
- cause_clr_i, input, 1: clears cause_o; honoured in IDLE only.
- arst_req_o, output, 1: registered reset request to the downstream arst stage.
- busy_o, output, 1: high whenever the FSM is not in IDLE.
- cause_o, output, NUM_SRC: sticky record of the sources that requested reset.
- rst_cnt_o, output, CNT_W: number of assertions of arst_req_o, saturating.

Behaviour:
- Define eff = req_i & ~req_mask_i. "Active" means eff is non-zero.
- On glob_arst_i, the block immediately and asynchronously enters IDLE with every register cleared:
  - arst_req_o=0, busy_o=0, cause_o=0, rst_cnt_o=0, timer=0, pending=0.
  - This applies in any state; there is no synchronous reset.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, ASSERT, HOLD, COOLDOWN.
- IDLE:
  - arst_req_o=0.
  - When eff is active: go to ASSERT, set arst_req_o=1 on that same edge (1-cycle latency from req_i), load timer with MIN_PULSE-1, and increment rst_cnt_o.
- ASSERT:
  - arst_req_o=1; timer decrements each cycle.
  - When timer reaches 0 and eff is active: go to HOLD. Otherwise go to COOLDOWN.
  - arst_req_o is therefore high for exactly MIN_PULSE cycles if eff is released early.
- HOLD:
  - arst_req_o=1 while eff is active.
  - The first cycle eff is zero: go to COOLDOWN, with arst_req_o=0 from that edge.
  - Total high time = max(MIN_PULSE, request duration).
- COOLDOWN:
  - arst_req_o=0; timer is loaded with HOLDOFF-1 on entry and decrements.
  - Any active eff seen during COOLDOWN sets pending.
  - When timer reaches 0: if pending is set or eff is active, go to ASSERT (re-trigger, rst_cnt_o increments, pending clears). Otherwise go to IDLE.
  - If HOLDOFF=0, COOLDOWN is skipped: ASSERT/HOLD exit to IDLE with arst_req_o=0 for at least 1 cycle, and a request present in that IDLE cycle re-triggers on the next edge.
- cause_o:
  - Every cycle, in every state other than reset, cause_o |= eff.
  - In IDLE, cause_clr_i=1 gives cause_o = eff; set wins over clear in the same cycle.
  - cause_clr_i is ignored in ASSERT, HOLD and COOLDOWN.
- rst_cnt_o saturates at 2^CNT_W-1 and never wraps.
- busy_o is registered and equals (state != IDLE).
- Mask changes take effect on the next cycle through eff. Masking all sources during HOLD releases the request.
- A source that stays high forever keeps arst_req_o high in HOLD indefinitely, with no re-count.
- Multiple sources arriving simultaneously or staggered produce one assertion, with all their bits recorded in cause_o.

Test Plan:
1. Reset release, all req_i=0 for 50 cycles -> arst_req_o=0, busy_o=0, cause_o=0, rst_cnt_o=0 throughout.
2. req_i[1] pulses for 1 cycle, defaults -> arst_req_o high exactly 16 cycles starting 1 cycle later; busy_o high for 16+8 cycles; cause_o=4'b0010; rst_cnt_o=1.
3. req_i[0] held for 40 cycles -> arst_req_o high 40 cycles (HOLD), then low; 8-cycle COOLDOWN; rst_cnt_o=1.
4. req_i[2] pulses during COOLDOWN cycle 3 -> after COOLDOWN ends, arst_req_o re-asserts for 16 cycles; rst_cnt_o=2; cause_o includes bit 2.
5. req_mask_i=4'b1000 with req_i[3] pulsing -> no assertion, cause_o=0. Then cause_clr_i in IDLE while req_i[0]=1 -> cause_o=4'b0001 and an assertion starts.
6. glob_arst_i pulsed mid-ASSERT, and separately with CNT_W=2 and 5 triggers -> arst_req_o drops immediately and all outputs are 0; counter reads 3 after the 5 triggers (saturated).
